burst_addr_gen: RTL and testbench

BURST_ADDR_GEN -- requirements
Module: burst_addr_gen

---
 rtl/burst_addr_gen.sv | 109 ++++++++++
 tb/tb_burst_addr_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/burst_addr_gen.sv
// Burst address generator: accepts one burst request, waits a fixed number of
// cycles, then emits one line address per beat (incrementing or wrapping).
module burst_addr_gen #(
  parameter  int ADDR      = 22,
  parameter  int DATA      = 5,
  parameter  int WAIT      = 10,
  parameter  int BURST_MAX = 8,
  localparam int LW        = $clog2(BURST_MAX)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [ADDR-1:0] req_addr,
  input  logic [LW-1:0]   req_len,
  input  logic            req_wrap,
  input  logic            flush,
  input  logic            out_ready,
  output logic            rdy,
  output logic [DATA-1:0] data,
  output logic [ADDR-1:3] newaddr,
  output logic            done
);

  localparam int LINE_W = ADDR - 3;
  localparam int WC     = (WAIT > 1) ? $clog2(WAIT + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAITING, BEAT} state_t;

  state_t            state, state_next;
  logic [LINE_W-1:0] line_q;
  logic [LW-1:0]     len_q;
  logic              wrap_q;
  logic [LW-1:0]     idx;
  logic [WC-1:0]     wcnt;

  logic              accept;
  logic              xfer;
  logic              last;
  logic [LW:0]       len_p1;
  logic              pow2;
  logic [LINE_W-1:0] mask;
  logic [LINE_W-1:0] sum;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[2:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and handshake outputs; flush wins over a beat transfer.
  always_comb begin
    state_next = state;
    req_ready  = (state == IDLE);
    rdy        = (state == BEAT);
    accept     = (state == IDLE) && req_valid;
    xfer       = (state == BEAT) && out_ready;
    last       = (idx == len_q);
    done       = xfer && last && !flush;
    case (state)
      IDLE:    if (req_valid) state_next = (WAIT == 0) ? BEAT : WAITING;
      WAITING: begin
        if (flush)                 state_next = IDLE;
        else if (wcnt == WC'(1))   state_next = BEAT;
      end
      BEAT: begin
        if (flush)                 state_next = IDLE;
        else if (xfer && last)     state_next = IDLE;
      end
      default:                     state_next = IDLE;
    endcase
  end

  // Request capture, wait countdown and beat index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
      len_q  <= '0;
      wrap_q <= 1'b0;
      idx    <= '0;
      wcnt   <= '0;
    end else if (accept) begin
      line_q <= req_addr[ADDR-1:3];
      len_q  <= req_len;
      wrap_q <= req_wrap;
      idx    <= '0;
      wcnt   <= WC'(WAIT);
    end else if (!flush) begin
      if (state == WAITING) wcnt <= wcnt - WC'(1);
      if (xfer)             idx  <= idx + LW'(1);
    end
  end

  // Wrapping only when len+1 is a power of two: then len itself is the mask
  // of the low address bits that roll over; otherwise plain increment.
  always_comb begin
    len_p1 = (LW+1)'(len_q) + (LW+1)'(1);
    pow2   = ((len_p1 & (LW+1)'(len_q)) == '0);
    mask   = LINE_W'(len_q);
    sum    = line_q + LINE_W'(idx);
  end

  assign newaddr = (wrap_q && pow2) ? ((line_q & ~mask) | (sum & mask)) : sum;
  assign data    = DATA'(idx);

endmodule

// File: tb/tb_burst_addr_gen.sv
// Randomized bench for burst_addr_gen: two instances (WAIT=10 and WAIT=0)
// checked against a transaction-level address model.
module tb_burst_addr_gen;

  localparam int ADDR   = 22;
  localparam int DATA   = 5;
  localparam int BMAX   = 8;
  localparam int LW     = 3;
  localparam int LINE_W = ADDR - 3;
  localparam int WAIT_A = 10;
  localparam int WAIT_B = 0;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic [ADDR-1:0] req_addr = '0;
  logic [LW-1:0]   req_len = '0;
  logic            req_wrap = 1'b0;
  logic            flush = 1'b0;
  logic            out_ready = 1'b0;
  int unsigned     cur_sel = 0;

  logic            req_valid_a, req_valid_b;
  logic            req_ready_a, req_ready_b, rdy_a, rdy_b, done_a, done_b;
  logic [DATA-1:0] data_a, data_b;
  logic [ADDR-1:3] newaddr_a, newaddr_b;

  logic            m_req_ready, m_rdy, m_done;
  logic [DATA-1:0] m_data;
  logic [ADDR-1:3] m_newaddr;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  assign req_valid_a = req_valid && (cur_sel == 0);
  assign req_valid_b = req_valid && (cur_sel == 1);

  assign m_req_ready = cur_sel ? req_ready_b : req_ready_a;
  assign m_rdy       = cur_sel ? rdy_b       : rdy_a;
  assign m_done      = cur_sel ? done_b      : done_a;
  assign m_data      = cur_sel ? data_b      : data_a;
  assign m_newaddr   = cur_sel ? newaddr_b   : newaddr_a;

  burst_addr_gen #(.ADDR(ADDR), .DATA(DATA), .WAIT(WAIT_A), .BURST_MAX(BMAX)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_addr(req_addr), .req_len(req_len), .req_wrap(req_wrap), .flush(flush),
    .out_ready(out_ready), .rdy(rdy_a), .data(data_a), .newaddr(newaddr_a), .done(done_a)
  );

  burst_addr_gen #(.ADDR(ADDR), .DATA(DATA), .WAIT(WAIT_B), .BURST_MAX(BMAX)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_addr(req_addr), .req_len(req_len), .req_wrap(req_wrap), .flush(flush),
    .out_ready(out_ready), .rdy(rdy_b), .data(data_b), .newaddr(newaddr_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s sel=%0d got=0x%0h exp=0x%0h t=%0t", tag, cur_sel, got, exp, $time);
    end
  endtask

  // Expected line address of beat i: aligned-block wrap when the burst size
  // is a power of two and wrap is requested, otherwise start + i modulo 2^LINE_W.
  function automatic logic [31:0] exp_line(input logic [LINE_W-1:0] s, input int unsigned len,
                                           input bit wrap, input int unsigned i);
    longint unsigned n  = len + 1;
    longint unsigned sl = s;
    longint unsigned r;
    if (wrap && ((n & (n - 1)) == 0)) r = (sl / n) * n + ((sl % n) + i) % n;
    else                              r = (sl + i) % (64'd1 << LINE_W);
    return 32'(r);
  endfunction

  // One request and its beats. rmode: 0 always ready, 1 random, 2 pattern 1,0,0,1.
  // flush_beat < 0 means no flush during the burst.
  task automatic run_burst(input int unsigned sel, input logic [ADDR-1:0] addr,
                           input int unsigned len, input bit wrap, input int unsigned rmode,
                           input int flush_beat, input bit flush_on_accept);
    int unsigned       w;
    int unsigned       i = 0;
    int unsigned       cyc = 0;
    bit                orr, fl, flushed = 0;
    logic [LINE_W-1:0] s;
    w = (sel != 0) ? WAIT_B : WAIT_A;
    s = addr[ADDR-1:3];
    cur_sel   = sel;
    req_addr  = addr;
    req_len   = len[LW-1:0];
    req_wrap  = wrap;
    req_valid = 1'b1;
    flush     = flush_on_accept;
    out_ready = 1'b0;
    #1;
    check("accept_req_ready", 32'(m_req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    req_addr  = ADDR'($urandom);
    req_len   = LW'($urandom);
    req_wrap  = 1'($urandom);
    for (int unsigned k = 0; k < w; k++) begin
      check("wait_rdy", 32'(m_rdy), 0);
      check("wait_req_ready", 32'(m_req_ready), 0);
      @(posedge clk); #1;
    end
    check("first_rdy", 32'(m_rdy), 1);
    while (i <= len && cyc < 200 && !flushed) begin
      case (rmode)
        0:       orr = 1'b1;
        1:       orr = ($urandom_range(0, 3) != 0);
        default: orr = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      endcase
      fl = (flush_beat == int'(i)) && orr;
      out_ready = orr;
      flush     = fl;
      #1;
      check("beat_rdy", 32'(m_rdy), 1);
      check("beat_req_ready", 32'(m_req_ready), 0);
      check("beat_addr", 32'(m_newaddr), exp_line(s, len, wrap, i));
      check("beat_data", 32'(m_data), i);
      check("beat_done", 32'(m_done), 32'(orr && !fl && (i == len)));
      @(posedge clk); #1;
      flush     = 1'b0;
      out_ready = 1'b0;
      cyc++;
      if (fl) begin
        flushed = 1;
        check("flush_req_ready", 32'(m_req_ready), 1);
        check("flush_rdy", 32'(m_rdy), 0);
        check("flush_idx_held", 32'(m_data), i);
      end else if (orr) begin
        i++;
      end
    end
    if (cyc >= 200) check("burst_timeout_cycles", cyc, 0);
    else if (!flushed) begin
      check("end_req_ready", 32'(m_req_ready), 1);
      check("end_rdy", 32'(m_rdy), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values before any clock edge.
    #2;
    for (int unsigned d = 0; d < 2; d++) begin
      cur_sel = d;
      #1;
      check("rst_req_ready", 32'(m_req_ready), 1);
      check("rst_rdy", 32'(m_rdy), 0);
      check("rst_done", 32'(m_done), 0);
      check("rst_data", 32'(m_data), 0);
      check("rst_newaddr", 32'(m_newaddr), 0);
    end
    #7 rst = 1'b0;
    @(posedge clk); #1;

    run_burst(0, 22'h000040, 3, 0, 0, -1, 0);
    run_burst(1, 22'h000068, 3, 1, 0, -1, 0);
    run_burst(0, 22'h12345F, 3, 0, 2, -1, 0);
    run_burst(0, 22'h0ABCD0, 7, 0, 0, 2, 0);
    run_burst(0, 22'h0ABCD0, 7, 1, 1, -1, 0);
    run_burst(1, 22'h2A0038, 7, 1, 0, -1, 1);
    run_burst(0, 22'h3FFFF8, 1, 0, 0, -1, 0);
    run_burst(1, 22'h3FFFF8, 1, 1, 0, -1, 0);
    run_burst(1, 22'h000078, 2, 1, 0, -1, 0);
    run_burst(1, 22'h0000F8, 5, 1, 1, -1, 0);

    // Asynchronous reset between edges while waiting.
    cur_sel   = 0;
    req_addr  = 22'h1F0F08;
    req_len   = 3'd5;
    req_wrap  = 1'b1;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("arst_req_ready", 32'(m_req_ready), 1);
    check("arst_rdy", 32'(m_rdy), 0);
    check("arst_done", 32'(m_done), 0);
    check("arst_data", 32'(m_data), 0);
    check("arst_newaddr", 32'(m_newaddr), 0);
    @(posedge clk); #1;
    check("arst_hold_rdy", 32'(m_rdy), 0);
    check("arst_hold_newaddr", 32'(m_newaddr), 0);
    #2 rst = 1'b0;
    for (int unsigned k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      check("post_rst_rdy", 32'(m_rdy), 0);
      check("post_rst_done", 32'(m_done), 0);
    end
    out_ready = 1'b0;
    run_burst(0, 22'h1F0F08, 5, 1, 0, -1, 0);

    // Randomized bursts over both instances.
    for (int unsigned t = 0; t < 40; t++) begin
      int unsigned len_r;
      int          fb;
      len_r = $urandom_range(0, BMAX - 1);
      fb    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len_r)) : -1;
      run_burst($urandom_range(0, 1), ADDR'($urandom), len_r, 1'($urandom),
                $urandom_range(0, 2), fb, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
